// File: rtl/alu_mdu.sv
// Execute-stage ALU: single-cycle arithmetic/logic/compare/shift ops plus an iterative
// multiply/divide unit (WIDTH steps + one fixup cycle) writing HI/LO. Registered outputs.
module alu_mdu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] op_1,
  input  logic [WIDTH-1:0] op_2,
  output logic [WIDTH-1:0] result,
  output logic             z,
  output logic             ovf,
  output logic             div0,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int SHAMT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t               state;
  logic [SHAMT_W-1:0]   cnt;
  logic [WIDTH-1:0]     p_hi, p_lo, opnd_b;
  logic                 md_mul, neg_q, neg_r, dz_q;

  logic [WIDTH-1:0]     sum, diff, alu_res, mag_a, mag_b;
  logic                 alu_ovf, is_md, is_mul, sgn, a_neg, b_neg, dz;
  logic [SHAMT_W-1:0]   shamt;
  logic [WIDTH:0]       mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0]   prod_mag, prod_fix;
  logic [WIDTH-1:0]     q_fix, r_fix, fix_hi, fix_lo;

  always_comb begin
    sum     = op_1 + op_2;
    diff    = op_1 - op_2;
    shamt   = op_2[SHAMT_W-1:0];
    alu_res = '0;
    alu_ovf = 1'b0;
    case (alu_op)
      4'h1: begin
        alu_res = sum;
        alu_ovf = (op_1[WIDTH-1] == op_2[WIDTH-1]) && (sum[WIDTH-1] != op_1[WIDTH-1]);
      end
      4'h2: begin
        alu_res = diff;
        alu_ovf = (op_1[WIDTH-1] != op_2[WIDTH-1]) && (diff[WIDTH-1] != op_1[WIDTH-1]);
      end
      4'h3: alu_res = op_1 ^ op_2;
      4'h4: alu_res = op_1 | op_2;
      4'h5: alu_res = op_1 & op_2;
      4'h6: alu_res = op_1 << shamt;
      4'h7: alu_res = op_1 >> shamt;
      4'h8: alu_res = ~(op_1 | op_2);
      4'h9: alu_res = {{(WIDTH-1){1'b0}}, ($signed(op_1) < $signed(op_2))};
      4'hA: alu_res = $signed(op_1) >>> shamt;
      4'hF: alu_res = {{(WIDTH-1){1'b0}}, (op_1 < op_2)};
      default: alu_res = '0;
    endcase

    is_md  = (alu_op >= 4'hB) && (alu_op <= 4'hE);
    is_mul = (alu_op == 4'hB) || (alu_op == 4'hC);
    sgn    = (alu_op == 4'hB) || (alu_op == 4'hD);
    a_neg  = sgn & op_1[WIDTH-1];
    b_neg  = sgn & op_2[WIDTH-1];
    dz     = !is_mul && (op_2 == '0);
    mag_a  = a_neg ? -op_1 : op_1;
    mag_b  = b_neg ? -op_2 : op_2;

    // Multiply: shift-add with the multiplier consumed from p_lo's LSB.
    mul_sum   = {1'b0, p_hi} + (p_lo[0] ? {1'b0, opnd_b} : {(WIDTH+1){1'b0}});
    // Divide: restoring; p_hi holds the partial remainder, quotient bits shift into p_lo.
    div_shift = {p_hi, p_lo[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_b};

    prod_mag = {p_hi, p_lo};
    prod_fix = neg_q ? -prod_mag : prod_mag;
    q_fix    = neg_q ? -p_lo : p_lo;
    r_fix    = neg_r ? -p_hi : p_hi;
    fix_hi   = md_mul ? prod_fix[2*WIDTH-1:WIDTH] : r_fix;
    fix_lo   = md_mul ? prod_fix[WIDTH-1:0] : q_fix;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      result <= '0;
      z      <= 1'b1;
      ovf    <= 1'b0;
      div0   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      p_hi   <= '0;
      p_lo   <= '0;
      opnd_b <= '0;
      md_mul <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz_q   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          div0 <= 1'b0;
          if (is_md) begin
            busy   <= 1'b1;
            ovf    <= 1'b0;
            state  <= CALC;
            cnt    <= '0;
            md_mul <= is_mul;
            dz_q   <= dz;
            // Divide by zero runs unsigned on the raw dividend so the remainder equals op_1.
            neg_q  <= dz ? 1'b0 : (a_neg ^ b_neg);
            neg_r  <= dz ? 1'b0 : a_neg;
            p_hi   <= '0;
            p_lo   <= dz ? op_1 : mag_a;
            opnd_b <= mag_b;
          end else begin
            result <= alu_res;
            z      <= (alu_res == '0);
            ovf    <= alu_ovf;
            done   <= 1'b1;
          end
        end
        CALC: begin
          if (md_mul) begin
            p_hi <= mul_sum[WIDTH:1];
            p_lo <= {mul_sum[0], p_lo[WIDTH-1:1]};
          end else if (!div_diff[WIDTH]) begin
            p_hi <= div_diff[WIDTH-1:0];
            p_lo <= {p_lo[WIDTH-2:0], 1'b1};
          end else begin
            p_hi <= div_shift[WIDTH-1:0];
            p_lo <= {p_lo[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt + 1'b1;
          if (cnt == SHAMT_W'(WIDTH-1)) state <= FIX;
        end
        FIX: begin
          hi     <= fix_hi;
          lo     <= fix_lo;
          result <= fix_lo;
          z      <= (fix_lo == '0);
          ovf    <= 1'b0;
          div0   <= dz_q;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_mdu.sv
// Directed self-checking bench for alu_mdu at WIDTH=32; inputs change and outputs are
// sampled on the falling edge.
module tb_alu_mdu;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [3:0]   alu_op;
  logic [W-1:0] op_1, op_2;
  logic [W-1:0] result, hi, lo;
  logic         z, ovf, div0, busy, done;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [3:0]   op;
    logic [W-1:0] a, b, r;
    logic         v;
  } vec_t;

  alu_mdu #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .alu_op(alu_op), .op_1(op_1), .op_2(op_2),
    .result(result), .z(z), .ovf(ovf), .div0(div0), .busy(busy), .done(done),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Returns on the falling edge just after the accepting rising edge.
  task automatic drive(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start = 1'b1; alu_op = op; op_1 = a; op_2 = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts falling edges with busy high; ends on the first falling edge with busy low.
  task automatic run_md(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int cyc);
    drive(op, a, b);
    cyc = 0;
    while (busy === 1'b1 && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; alu_op = 4'h0; op_1 = '0; op_2 = '0;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({result, hi, lo} !== {3*W{1'b0}}) begin
      n_fail++; $display("FAIL reset_regs: result=%h hi=%h lo=%h, want all 0", result, hi, lo);
    end
    n_tests++;
    if ({z, ovf, div0, busy, done} !== 5'b10000) begin
      n_fail++; $display("FAIL reset_flags: z,ovf,div0,busy,done=%b, want 10000",
                         {z, ovf, div0, busy, done});
    end
    rst = 1'b0;
  endtask

  task automatic test_add_ovf;
    drive(4'h1, 32'h7FFF_FFFF, 32'h0000_0001);
    n_tests++;
    if ({result, ovf, z, done, busy} !== {32'h8000_0000, 4'b1010}) begin
      n_fail++; $display("FAIL add_ovf: result=%h ovf=%b z=%b done=%b busy=%b, want 80000000 1 0 1 0",
                         result, ovf, z, done, busy);
    end
    @(negedge clk);
    n_tests++;
    if ({done, result} !== {1'b0, 32'h8000_0000}) begin
      n_fail++; $display("FAIL add_hold: done=%b result=%h, want 0 80000000", done, result);
    end
  endtask

  task automatic test_single;
    vec_t vecs[13];
    logic [W-1:0] zero_w;
    zero_w    = '0;
    vecs[0]   = '{4'h2, 32'd5,         32'd5,         32'd0,         1'b0};
    vecs[1]   = '{4'hA, 32'h8000_0000, 32'd4,         32'hF800_0000, 1'b0};
    vecs[2]   = '{4'hF, 32'd1,         32'hFFFF_FFFF, 32'd1,         1'b0};
    vecs[3]   = '{4'h9, 32'd1,         32'hFFFF_FFFF, 32'd0,         1'b0};
    vecs[4]   = '{4'h3, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0};
    vecs[5]   = '{4'h4, 32'h0000_F000, 32'h0000_000F, 32'h0000_F00F, 1'b0};
    vecs[6]   = '{4'h5, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00, 1'b0};
    vecs[7]   = '{4'h8, 32'd0,         32'd0,         32'hFFFF_FFFF, 1'b0};
    vecs[8]   = '{4'h6, 32'd1,         32'h0000_0025, 32'h0000_0020, 1'b0};
    vecs[9]   = '{4'h7, 32'h8000_0000, 32'd31,        32'd1,         1'b0};
    vecs[10]  = '{4'h0, 32'd12,        32'd34,        32'd0,         1'b0};
    vecs[11]  = '{4'h2, 32'h8000_0000, 32'd1,         32'h7FFF_FFFF, 1'b1};
    vecs[12]  = '{4'h1, 32'hFFFF_FFFF, 32'd1,         32'd0,         1'b0};
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].op, vecs[i].a, vecs[i].b);
      n_tests++;
      if (result !== vecs[i].r) begin
        n_fail++; $display("FAIL single[%0d] result: got %h want %h", i, result, vecs[i].r);
      end
      n_tests++;
      if ({z, ovf, done} !== {(vecs[i].r == zero_w), vecs[i].v, 1'b1}) begin
        n_fail++; $display("FAIL single[%0d] z/ovf/done: got %b%b%b want %b%b1", i, z, ovf, done,
                           (vecs[i].r == zero_w), vecs[i].v);
      end
    end
  endtask

  task automatic test_mult;
    int cyc;
    run_md(4'hB, 32'hFFFF_FFFD, 32'd7, cyc);
    n_tests++;
    if (cyc !== 33) begin
      n_fail++; $display("FAIL mult_busy_cycles: got %0d want 33", cyc);
    end
    n_tests++;
    if ({done, hi, lo, result} !== {1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 32'hFFFF_FFEB}) begin
      n_fail++; $display("FAIL mult: done=%b hi=%h lo=%h result=%h, want 1 ffffffff ffffffeb ffffffeb",
                         done, hi, lo, result);
    end
    run_md(4'hC, 32'hFFFF_FFFF, 32'd2, cyc);
    n_tests++;
    if ({done, hi, lo} !== {1'b1, 32'd1, 32'hFFFF_FFFE}) begin
      n_fail++; $display("FAIL multu: done=%b hi=%h lo=%h, want 1 00000001 fffffffe", done, hi, lo);
    end
  endtask

  task automatic test_div;
    int cyc;
    run_md(4'hD, 32'hFFFF_FFF9, 32'd2, cyc);
    n_tests++;
    if ({hi, lo, div0, cyc} !== {32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 32'd33}) begin
      n_fail++; $display("FAIL div_neg: hi=%h lo=%h div0=%b cyc=%0d, want ffffffff fffffffd 0 33",
                         hi, lo, div0, cyc);
    end
    run_md(4'hD, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
    n_tests++;
    if ({hi, lo, ovf, div0} !== {32'd0, 32'h8000_0000, 2'b00}) begin
      n_fail++; $display("FAIL div_min: hi=%h lo=%h ovf=%b div0=%b, want 0 80000000 0 0",
                         hi, lo, ovf, div0);
    end
    run_md(4'hE, 32'd100, 32'd7, cyc);
    n_tests++;
    if ({hi, lo, z} !== {32'd2, 32'd14, 1'b0}) begin
      n_fail++; $display("FAIL divu: hi=%h lo=%h z=%b, want 2 e 0", hi, lo, z);
    end
    run_md(4'hE, 32'd9, 32'd0, cyc);
    n_tests++;
    if ({div0, hi, lo, cyc} !== {1'b1, 32'd9, 32'hFFFF_FFFF, 32'd33}) begin
      n_fail++; $display("FAIL div0: div0=%b hi=%h lo=%h cyc=%0d, want 1 9 ffffffff 33",
                         div0, hi, lo, cyc);
    end
    drive(4'h1, 32'd2, 32'd3);
    n_tests++;
    if ({div0, result} !== {1'b0, 32'd5}) begin
      n_fail++; $display("FAIL div0_clear: div0=%b result=%h, want 0 5", div0, result);
    end
  endtask

  task automatic test_back_to_back;
    logic early;
    early = 1'b0;
    drive(4'hB, 32'hFFFF_FFFD, 32'd7);
    for (int k = 0; k < 33; k++) begin
      start = (k == 4) || (k == 32);
      alu_op = 4'h1; op_1 = 32'd1; op_2 = 32'd1;
      @(negedge clk);
      if (k < 32 && done === 1'b1) early = 1'b1;
    end
    n_tests++;
    if (early !== 1'b0) begin
      n_fail++; $display("FAIL ignore_early_done: got early done, want none");
    end
    n_tests++;
    if ({done, busy, hi, lo, result} !== {2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 32'hFFFF_FFEB}) begin
      n_fail++; $display("FAIL ignore_mult: done=%b busy=%b hi=%h lo=%h result=%h, want 1 0 ffffffff ffffffeb ffffffeb",
                         done, busy, hi, lo, result);
    end
    op_1 = 32'd3; op_2 = 32'd4;
    @(negedge clk);
    start = 1'b0;
    n_tests++;
    if ({done, result, hi, lo} !== {1'b1, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB}) begin
      n_fail++; $display("FAIL done_cycle_accept: done=%b result=%h hi=%h lo=%h, want 1 7 ffffffff ffffffeb",
                         done, result, hi, lo);
    end
  endtask

  task automatic test_reset_mid;
    logic seen;
    seen = 1'b0;
    drive(4'hD, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({busy, hi, lo, result, z} !== {1'b0, 96'd0, 1'b1}) begin
      n_fail++; $display("FAIL reset_mid: busy=%b hi=%h lo=%h result=%h z=%b, want 0 0 0 0 1",
                         busy, hi, lo, result, z);
    end
    rst = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    n_tests++;
    if (seen !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_no_done: activity after reset, want none");
    end
  endtask

  initial begin
    test_reset;
    test_add_ovf;
    test_single;
    test_mult;
    test_div;
    test_back_to_back;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
